cmult_scheduler: RTL and testbench

Shares one complex multiplier datapath between `N_REQ` independent requesters. Arbitrates valid/ready operand requests, issues at most one multiply per cycle, and tracks each in-flight product's requester ID through the fixed pipeline. Buffers results in a credit-protected output FIFO. Sits between channel front-ends (e.g. per-channel mixers/NCOs) and the shared multiplier, so several low-rate streams reuse a single 4-DSP48 multiplier.

---
 rtl/cmult_scheduler_pkg.sv | 21 ++
 rtl/complex_multiplier.sv | 53 +++++
 rtl/cmult_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_cmult_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmult_scheduler_pkg.sv
// cmult_scheduler_pkg
// Shared definitions for the complex-multiplier scheduler: multiplier pipeline
// latency and the complex product width helper. Complex values are carried as
// packed {re, im} vectors, re in the upper half, both parts two's complement.
// Ports: none (package).
package cmult_scheduler_pkg;

  // Register stages from operand sample to product output in complex_multiplier.
  localparam int unsigned CMULT_LAT = 3;

  // Width of each part of a full-precision complex product.
  function automatic int unsigned c_width(int unsigned a_w, int unsigned b_w);
    return a_w + b_w + 1;
  endfunction

  // Width of a packed result entry {id, re, im}.
  function automatic int unsigned entry_width(int unsigned id_w, int unsigned cw);
    return id_w + 2 * cw;
  endfunction

endpackage

// File: rtl/complex_multiplier.sv
// complex_multiplier
// Fully pipelined signed complex multiplier, c = a * b, latency CMULT_LAT (3).
// Stage 1 registers the operands, stage 2 the four partial products, stage 3
// the re/im sums. No reset: downstream logic tracks validity separately.
// Ports:
//   clk - rising-edge clock
//   a   - operand a, packed {re, im}, A_WIDTH bits per part
//   b   - operand b, packed {re, im}, B_WIDTH bits per part
//   c   - product, packed {re, im}, A_WIDTH+B_WIDTH+1 bits per part
module complex_multiplier
  import cmult_scheduler_pkg::*;
#(
  parameter int unsigned A_WIDTH = 10,
  parameter int unsigned B_WIDTH = 11,
  localparam int unsigned C_WIDTH = c_width(A_WIDTH, B_WIDTH)
) (
  input  logic                   clk,
  input  logic [2*A_WIDTH-1:0]   a,
  input  logic [2*B_WIDTH-1:0]   b,
  output logic [2*C_WIDTH-1:0]   c
);

  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;

  logic [A_WIDTH-1:0] ar_q, ai_q;
  logic [B_WIDTH-1:0] br_q, bi_q;

  logic signed [P_WIDTH-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [P_WIDTH-1:0] rr_q, ii_q, ri_q, ir_q;
  logic signed [C_WIDTH-1:0] re_q, im_q;

  // Sign-extend to the product width so the multiply is P_WIDTH x P_WIDTH.
  assign ar_x = $signed({{B_WIDTH{ar_q[A_WIDTH-1]}}, ar_q});
  assign ai_x = $signed({{B_WIDTH{ai_q[A_WIDTH-1]}}, ai_q});
  assign br_x = $signed({{A_WIDTH{br_q[B_WIDTH-1]}}, br_q});
  assign bi_x = $signed({{A_WIDTH{bi_q[B_WIDTH-1]}}, bi_q});

  always_ff @(posedge clk) begin
    ar_q <= a[2*A_WIDTH-1:A_WIDTH];
    ai_q <= a[A_WIDTH-1:0];
    br_q <= b[2*B_WIDTH-1:B_WIDTH];
    bi_q <= b[B_WIDTH-1:0];
    rr_q <= ar_x * br_x;
    ii_q <= ai_x * bi_x;
    ri_q <= ar_x * bi_x;
    ir_q <= ai_x * br_x;
    re_q <= $signed({rr_q[P_WIDTH-1], rr_q}) - $signed({ii_q[P_WIDTH-1], ii_q});
    im_q <= $signed({ri_q[P_WIDTH-1], ri_q}) + $signed({ir_q[P_WIDTH-1], ir_q});
  end

  assign c = {re_q, im_q};

endmodule

// File: rtl/cmult_scheduler.sv
// cmult_scheduler
// Shares one pipelined complex multiplier between N_REQ requesters. An inline
// arbiter grants at most one valid/ready request per cycle while result
// credits remain; a tag pipeline carries {valid, id} alongside the multiplier
// and completed products land in an inline result FIFO.
// Build option: define CMULT_SCHED_FIXED_PRIO_EN for fixed priority (lowest
// index wins); otherwise round-robin starting at rr_ptr.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid/req_ready - per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b        - per-requester operands, packed {re, im}
//   res_valid/res_ready - result handshake at FIFO head
//   res_id, res_c       - head result requester index and product {re, im}
module cmult_scheduler
  import cmult_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned A_WIDTH    = 10,
  parameter int unsigned B_WIDTH    = 11,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned C_WIDTH   = c_width(A_WIDTH, B_WIDTH),
  localparam int unsigned ID_W      = $clog2(N_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ-1:0][2*A_WIDTH-1:0] req_a,
  input  logic [N_REQ-1:0][2*B_WIDTH-1:0] req_b,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [ID_W-1:0]                 res_id,
  output logic [2*C_WIDTH-1:0]            res_c
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned E_W   = entry_width(ID_W, C_WIDTH);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             can_issue;
  logic             gnt_any;
  logic [ID_W-1:0]  gnt_idx;

  logic [2*A_WIDTH-1:0] mult_a;
  logic [2*B_WIDTH-1:0] mult_b;
  logic [2*C_WIDTH-1:0] mult_c;

  logic [CMULT_LAT-1:0]           tag_vld_q;
  logic [CMULT_LAT-1:0][ID_W-1:0] tag_id_q;
  logic                           push, pop;

  logic [E_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [E_W-1:0]   head;

  // Every issued product owns a FIFO slot until it is popped.
  assign can_issue = ({1'b0, fifo_count_q} + {1'b0, inflight_q}) < DEPTH_C;

  // ---------------------------------------------------------------- arbiter
`ifdef CMULT_SCHED_FIXED_PRIO_EN
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (can_issue && rst_n) begin
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = ID_W'(i);
        end
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr_q;
  int unsigned     rr_idx;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    if (can_issue && rst_n) begin
      for (int unsigned off = 0; off < N_REQ; off++) begin
        rr_idx = (32'(rr_ptr_q) + off) % N_REQ;
        if (!gnt_any && req_valid[rr_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = ID_W'(rr_idx);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (gnt_any) begin
      rr_ptr_q <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Zero operands when idle so the datapath does not toggle on stale inputs.
  assign mult_a = gnt_any ? req_a[gnt_idx] : '0;
  assign mult_b = gnt_any ? req_b[gnt_idx] : '0;

  complex_multiplier #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH)
  ) u_mult (
    .clk (clk),
    .a   (mult_a),
    .b   (mult_b),
    .c   (mult_c)
  );

  // ----------------------------------------------------------- tag pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q <= {tag_vld_q[CMULT_LAT-2:0], gnt_any};
      tag_id_q  <= {tag_id_q[CMULT_LAT-2:0], gnt_idx};
    end
  end

  assign push = tag_vld_q[CMULT_LAT-1];
  assign pop  = res_valid & res_ready;

  // ------------------------------------------------------------ result FIFO
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {tag_id_q[CMULT_LAT-1], mult_c};
    end
  end

  always_comb begin
    fifo_count_d = fifo_count_q;
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + CNT_W'(1);
    end else if (!push && pop) begin
      fifo_count_d = fifo_count_q - CNT_W'(1);
    end
    inflight_d = inflight_q;
    if (gnt_any && !push) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!gnt_any && push) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_count_q <= '0;
      inflight_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      fifo_count_q <= fifo_count_d;
      inflight_q   <= inflight_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  assign head      = fifo_mem[rd_ptr_q];
  assign res_valid = (fifo_count_q != '0);
  // Head fields are forced to zero when empty so reset and idle outputs are clean.
  assign res_id    = res_valid ? head[E_W-1:2*C_WIDTH] : '0;
  assign res_c     = res_valid ? head[2*C_WIDTH-1:0] : '0;

  // The credit check must make a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && ({1'b0, fifo_count_q} == DEPTH_C)));

endmodule

// File: tb/tb_cmult_scheduler.sv
module tb_cmult_scheduler;
  localparam int N = 4, AW = 10, BW = 11, CW = 22, DEPTH = 8, LAT = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N-1:0]             req_valid;
  logic [N-1:0]             req_ready;
  logic [N-1:0][2*AW-1:0]   req_a;
  logic [N-1:0][2*BW-1:0]   req_b;
  logic                     res_valid;
  logic                     res_ready;
  logic [1:0]               res_id;
  logic [2*CW-1:0]          res_c;

  cmult_scheduler #(
    .N_REQ      (N),
    .A_WIDTH    (AW),
    .B_WIDTH    (BW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_c     (res_c)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ------------------------------------------------ reference model / monitor
  // Scoreboard holds every accepted request in issue order with its expected
  // product and the cycle it was accepted; its size is the outstanding credit.
  typedef struct {
    int     id;
    int     re;
    int     im;
    longint t;
  } sb_t;
  sb_t    sb[$];
  longint cyc = 0;
  int     exp_g;
  logic [N-1:0] exp_rdy;
  bit     exp_v;
  logic signed [AW-1:0] m_ar, m_ai;
  logic signed [BW-1:0] m_br, m_bi;
  logic signed [CW-1:0] got_re, got_im;
  sb_t    e;
`ifndef CMULT_SCHED_FIXED_PRIO_EN
  int     rr_m = 0;
`endif

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_res_c", res_c, 0);
      sb.delete();
`ifndef CMULT_SCHED_FIXED_PRIO_EN
      rr_m = 0;
`endif
    end else begin
      cyc++;
      exp_g = -1;
      if (sb.size() < DEPTH) begin
`ifdef CMULT_SCHED_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--) if (req_valid[i]) exp_g = i;
`else
        for (int o = 0; o < N; o++)
          if (exp_g < 0 && req_valid[(rr_m + o) % N]) exp_g = (rr_m + o) % N;
`endif
      end
      exp_rdy = '0;
      if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
      chk("grant", req_ready, exp_rdy);

      exp_v = (sb.size() > 0) && (cyc >= sb[0].t + LAT);
      chk("res_valid", res_valid, exp_v);
      if (exp_v && res_ready) begin
        got_re = res_c[2*CW-1:CW];
        got_im = res_c[CW-1:0];
        chk("res_id", res_id, sb[0].id);
        chk("res_re", int'(got_re), sb[0].re);
        chk("res_im", int'(got_im), sb[0].im);
        void'(sb.pop_front());
      end

      if (exp_g >= 0) begin
        m_ar = req_a[exp_g][2*AW-1:AW];
        m_ai = req_a[exp_g][AW-1:0];
        m_br = req_b[exp_g][2*BW-1:BW];
        m_bi = req_b[exp_g][BW-1:0];
        e.id = exp_g;
        e.re = int'(m_ar) * int'(m_br) - int'(m_ai) * int'(m_bi);
        e.im = int'(m_ar) * int'(m_bi) + int'(m_ai) * int'(m_br);
        e.t  = cyc;
        sb.push_back(e);
`ifndef CMULT_SCHED_FIXED_PRIO_EN
        rr_m = (exp_g + 1) % N;
`endif
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  typedef struct {
    int id;
    int ar, ai, br, bi;
    int er, ei;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [2*AW-1:0] rand_a();
    if ($urandom_range(7) == 0) return {10'h200, 10'h200};
    return 20'($urandom);
  endfunction

  function automatic logic [2*BW-1:0] rand_b();
    if ($urandom_range(7) == 0) return {11'h400, 11'h400};
    return 22'($urandom);
  endfunction

  // Entered and left at posedge+1.
  task automatic idle(input int n);
    req_valid = '0;
    res_ready = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One cycle of random traffic; operands change only after acceptance.
  task automatic cycle_drive(input int pv, input int pr, output logic [N-1:0] acc,
                             output bit popped);
    @(negedge clk);
    acc    = req_valid & req_ready;
    popped = res_valid & res_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] || !req_valid[i]) begin
        req_a[i]     = rand_a();
        req_b[i]     = rand_b();
        req_valid[i] = ($urandom_range(99) < pv);
      end
    end
    res_ready = ($urandom_range(99) < pr);
  endtask

  task automatic run_vec(input vec_t v);
    logic [AW-1:0] ar, ai;
    logic [BW-1:0] br, bi;
    logic signed [CW-1:0] cre, cim;
    bit got;
    int n;
    ar = AW'(v.ar); ai = AW'(v.ai); br = BW'(v.br); bi = BW'(v.bi);
    req_a[v.id]     = {ar, ai};
    req_b[v.id]     = {br, bi};
    req_valid       = '0;
    req_valid[v.id] = 1'b1;
    res_ready       = 1'b1;
    #1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (req_ready[v.id]) got = 1'b1;
      else begin
        @(posedge clk);
        #2;
      end
    end
    chk("vec_accept", got, 1);
    @(posedge clk);
    #1;
    req_valid = '0;
    n = 1;
    while (!res_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    cre = res_c[2*CW-1:CW];
    cim = res_c[CW-1:0];
    chk("vec_latency", n, LAT);
    chk("vec_id", res_id, v.id);
    chk("vec_re", int'(cre), v.er);
    chk("vec_im", int'(cim), v.ei);
    @(posedge clk);
    #1;
    chk("vec_pulse", res_valid, 0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [N-1:0] acc;
  bit           popped;
  int           n_gnt, first_pop, first_gnt;

  initial begin
    vecs[0] = '{2, 3, -4, 5, 6, 39, -2};
    vecs[1] = '{0, -512, -512, -1024, -1024, 0, 1048576};
    vecs[2] = '{1, 1, 0, 7, -3, 7, -3};
    vecs[3] = '{3, -1, 2, 4, 5, -14, 3};
    vecs[4] = '{0, 511, 511, 1023, 1023, 0, 1045506};
    vecs[5] = '{1, -512, 511, 1023, -1024, -512, 1047041};

    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_a[i] = '0;
      req_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_res_valid", res_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    rst_n = 1'b1;
    idle(2);

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      idle(2);
    end

`ifdef CMULT_SCHED_FIXED_PRIO_EN
    // Requester 1 starves requester 3 until it drops.
    req_valid = 4'b1010;
    res_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("fix_grant1", req_ready, 4'b0010);
      @(posedge clk);
      #1;
    end
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("fix_grant3", req_ready, 4'b1000);
    @(posedge clk);
    #1;
    idle(12);
`else
    // Round-robin order from a fresh pointer with all requesters valid.
    do_reset();
    req_valid = '1;
    res_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cycle_drive(100, 100, acc, popped);
      chk("rr_order", acc, 4'b0001 << (k % 4));
    end
    idle(12);
`endif

    // Backpressure: exactly DEPTH grants, then one cycle from first pop to resume.
    do_reset();
    req_valid = '1;
    res_ready = 1'b0;
    n_gnt = 0;
    for (int k = 0; k < 20; k++) begin
      cycle_drive(100, 0, acc, popped);
      n_gnt += $countones(acc);
    end
    chk("bp_grants", n_gnt, DEPTH);
    res_ready = 1'b1;
    first_pop = -1;
    first_gnt = -1;
    for (int k = 0; k < 30; k++) begin
      cycle_drive(100, 100, acc, popped);
      if (popped && first_pop < 0) first_pop = k;
      if (acc != 0 && first_gnt < 0) first_gnt = k;
    end
    chk("bp_resume_gap", first_gnt - first_pop, 1);
    idle(15);

    // Reset with 3 products in flight and 2 results queued.
    do_reset();
    req_valid = '1;
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) cycle_drive(100, 0, acc, popped);
    chk("pre_rst_valid", res_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(10);
    run_vec(vecs[0]);
    idle(2);

    // Random traffic against the scoreboard.
    for (int k = 0; k < 800; k++) cycle_drive(60, 70, acc, popped);
    idle(30);
    chk("drain_empty", sb.size(), 0);
    chk("drain_res_valid", res_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
